usb_device_protocol_fsm: RTL and testbench
==========================================

Name: usb_device_protocol_fsm

Overview:
Device-side (function-end) USB transaction responder; the counterpart to the host protocol FSM.
- Consumes decoded packets (token, data, handshake) from the receive decoder.
- Answers IN tokens with a 64-bit data packet and OUT tokens with a handshake.
- Drives the transmit encoder through a req/done handshake.
- Exchanges payloads with the device application through a simple valid/ready buffer interface.

Parameters:
DEV_ADDR, 7'd5, device address this block responds to
DEV_ENDP, 4'd4, endpoint this block responds to
TIMEOUT_CYCLES, 255, cycles to wait for the host's next packet before abandoning the transaction
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
pkt_valid  in  1  one-cycle strobe: decoded packet fields valid
pid_in  in  4  received PID
addr_in  in  7  received token address
endp_in  in  4  received token endpoint
data_in  in  64  received data payload
crc_correct  in  1  received packet CRC good (qualified by pkt_valid)
send_req  out  1  request encoder to transmit pid_out/data_out
send_done  in  1  one-cycle strobe: encoder finished the packet
pid_out  out  4  PID to transmit
data_out  out  64  payload to transmit (DATA packets only)
crc_type  out  5  5'd16 for DATA packets, 5'd0 for handshakes
app_tx_valid  in  1  application has an IN payload pending
app_tx_data  in  64  IN payload
app_tx_taken  out  1  one-cycle pulse: host ACKed the payload
app_rx_ready  in  1  application can accept an OUT payload
app_rx_valid  out  1  one-cycle pulse: app_rx_data holds a new payload
app_rx_data  out  64  latched OUT payload
timeout_err  out  1  one-cycle pulse: transaction abandoned on timeout
err_count  out  ERR_CNT_W  saturating count of corrupted DATA packets and timeouts

Behaviour:
- Clock and reset: single clock clk; reset rst_b is asynchronous, active-low.
- Reset: state IDLE; all outputs and counters 0.
- All outputs are registered.
- PIDs: OUT=0001, IN=1001, DATA0=0011, DATA1=1011, ACK=0010, NAK=1010.
- A token matches when pkt_valid && crc_correct && addr_in==DEV_ADDR && endp_in==DEV_ENDP.
- States: IDLE, TX_DATA, WAIT_HS, RX_DATA, TX_HS.
- IDLE, matching IN token:
  - app_tx_valid=1: load pid_out=DATA0, data_out=app_tx_data, crc_type=16; go to TX_DATA.
  - Otherwise: load pid_out=NAK, crc_type=0; go to TX_HS.
- IDLE, matching OUT token: go to RX_DATA with timer=0.
- IDLE, anything else (non-matching or bad-CRC token): ignored.
- TX_DATA / TX_HS:
  - send_req held at 1 until the send_done cycle; send_req deasserts the following cycle.
  - TX_DATA then goes to WAIT_HS (timer=0); TX_HS then goes to IDLE.
  - pkt_valid is ignored in both states.
- WAIT_HS:
  - pkt_valid with pid_in=ACK and crc_correct: pulse app_tx_taken; go to IDLE.
  - Any other pkt_valid: go to IDLE without taken; the application keeps its data.
  - Timer: increments each cycle. When timer==TIMEOUT_CYCLES without pkt_valid: pulse timeout_err, err_count+1, go to IDLE.
- RX_DATA:
  - pkt_valid with pid_in DATA0/DATA1 and crc_correct:
    - app_rx_ready=1: latch data_in into app_rx_data, pulse app_rx_valid, pid_out=ACK.
    - app_rx_ready=0: pid_out=NAK.
  - pkt_valid with pid_in DATA0/DATA1 and crc_correct=0: pid_out=NAK, err_count+1.
  - In all three cases above, go to TX_HS.
  - Non-DATA pid: go to IDLE.
  - Timeout is handled as in WAIT_HS.
- Simultaneous pkt_valid and timer expiry: the packet wins; no timeout.
- err_count saturates at all-ones.
- Latency: IN token to send_req=1 is 1 cycle. DATA packet to send_req=1 (handshake) is 1 cycle.
- Reset mid-transaction: immediate return to IDLE. Pending app data is untouched; no pulses are emitted.

Optional Feature:
Macro USB_DEV_DATA_TOGGLE_EN.
- Enabled:
  - tx_toggle bit flips on each ACK received in WAIT_HS; the IN response uses DATA0 or DATA1 per tx_toggle.
  - rx_toggle tracks the expected OUT PID. A good DATA packet whose toggle mismatches is ACKed, but produces no app_rx_valid (duplicate) and rx_toggle does not flip.
  - A matching, accepted packet flips rx_toggle.
  - Both toggles reset to 0.
- Disabled: always transmit DATA0, accept DATA0 and DATA1 alike, no duplicate detection.

Decomposition:
- usb_pkg: PID enum, CRC_TYPE_5/CRC_TYPE_16/CRC_TYPE_NONE constants, state enum typedef.
- Sub-module usb_timeout_timer: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
1. IN token (addr 5, endp 4), app_tx_valid=1, data 64'hDEADBEEF_01234567 -> send_req with DATA0/crc_type 16/that data; host ACK -> app_tx_taken pulse, IDLE.
2. IN token, app_tx_valid=0 -> NAK sent, crc_type 0, no taken pulse.
3. OUT token then DATA0 with crc_correct=1, app_rx_ready=1 -> app_rx_valid pulse, app_rx_data=payload, ACK sent; repeat with crc_correct=0 -> NAK, err_count=1, no app_rx_valid.
4. IN token, DATA sent, no host response -> timeout_err exactly TIMEOUT_CYCLES cycles after WAIT_HS entry, err_count+1; ACK arriving on the expiry cycle -> taken pulse, no timeout.
5. Token addr 6 or bad CRC -> no send_req, state stays IDLE; rst_b asserted in WAIT_HS -> IDLE, outputs 0.
6. (USB_DEV_DATA_TOGGLE_EN) two ACKed IN transactions -> DATA0 then DATA1; repeated OUT DATA0 -> second ACKed without app_rx_valid.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB device-side transaction responder:
// PID encodings, CRC-type selectors for the transmit encoder, FSM states
// and a small PID classification helper.
package usb_pkg;

    // Packet identifiers (low nibble of the PID byte).
    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_ACK   = 4'b0010,
        PID_DATA0 = 4'b0011,
        PID_IN    = 4'b1001,
        PID_NAK   = 4'b1010,
        PID_DATA1 = 4'b1011
    } usb_pid_e;

    // CRC selection presented to the transmit encoder alongside pid_out.
    localparam logic [4:0] CRC_TYPE_NONE = 5'd0;
    localparam logic [4:0] CRC_TYPE_5    = 5'd5;
    localparam logic [4:0] CRC_TYPE_16   = 5'd16;

    // Transaction FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_DATA,
        ST_WAIT_HS,
        ST_RX_DATA,
        ST_TX_HS
    } usb_state_e;

    // True for either DATA PID; the toggle bit is judged separately.
    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// Host-response timer for the device transaction FSM. Counts cycles while
// enabled, holds at the limit, and flags expiry while the count sits at
// TIMEOUT_CYCLES. clear has priority over enable.
module usb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Cycle counter: restarts on clear, saturates at the limit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/usb_device_protocol_fsm.sv
// Device-side USB transaction responder. Answers IN tokens with a DATA
// packet (or NAK when the application has nothing queued), answers OUT
// transactions with ACK/NAK, and hands payloads to/from the application.
// All outputs are registered; the encoder is driven with a req/done pair.
// Optional build macro: USB_DEV_DATA_TOGGLE_EN enables DATA0/DATA1
// sequencing and duplicate-OUT detection.
module usb_device_protocol_fsm
    import usb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'd5,
    parameter logic [3:0] DEV_ENDP       = 4'd4,
    parameter int         TIMEOUT_CYCLES = 255,
    parameter int         ERR_CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 pkt_valid,
    input  logic [3:0]           pid_in,
    input  logic [6:0]           addr_in,
    input  logic [3:0]           endp_in,
    input  logic [63:0]          data_in,
    input  logic                 crc_correct,
    output logic                 send_req,
    input  logic                 send_done,
    output logic [3:0]           pid_out,
    output logic [63:0]          data_out,
    output logic [4:0]           crc_type,
    input  logic                 app_tx_valid,
    input  logic [63:0]          app_tx_data,
    output logic                 app_tx_taken,
    input  logic                 app_rx_ready,
    output logic                 app_rx_valid,
    output logic [63:0]          app_rx_data,
    output logic                 timeout_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    usb_state_e state, state_d;

    logic                 send_req_d;
    logic [3:0]           pid_out_d;
    logic [63:0]          data_out_d;
    logic [4:0]           crc_type_d;
    logic                 app_tx_taken_d;
    logic                 app_rx_valid_d;
    logic [63:0]          app_rx_data_d;
    logic                 timeout_err_d;
    logic [ERR_CNT_W-1:0] err_count_d;

    logic       token_match;
    logic       waiting;
    logic       tmo_expired;
    logic [3:0] tx_data_pid;
    logic       rx_dup;

    // Error counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    assign token_match = pkt_valid && crc_correct &&
                         (addr_in == DEV_ADDR) && (endp_in == DEV_ENDP);

    // The timer runs only while waiting on the host; any other state
    // holds it at zero so each wait starts from a fresh count.
    assign waiting = (state == ST_WAIT_HS) || (state == ST_RX_DATA);

    usb_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_b  (rst_b),
        .clear  (!waiting),
        .enable (waiting),
        .expired(tmo_expired)
    );

`ifdef USB_DEV_DATA_TOGGLE_EN
    logic tx_toggle, tx_toggle_d;
    logic rx_toggle, rx_toggle_d;

    assign tx_data_pid = tx_toggle ? PID_DATA1 : PID_DATA0;
    // A DATA PID whose toggle differs from the expected one is a retry of
    // a packet we already accepted (our ACK was lost).
    assign rx_dup      = (pid_in == PID_DATA1) != rx_toggle;

    // Data-toggle state for both directions.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tx_toggle <= 1'b0;
            rx_toggle <= 1'b0;
        end else begin
            tx_toggle <= tx_toggle_d;
            rx_toggle <= rx_toggle_d;
        end
    end
`else
    assign tx_data_pid = PID_DATA0;
    assign rx_dup      = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= ST_IDLE;
            send_req     <= 1'b0;
            pid_out      <= 4'd0;
            data_out     <= 64'd0;
            crc_type     <= CRC_TYPE_NONE;
            app_tx_taken <= 1'b0;
            app_rx_valid <= 1'b0;
            app_rx_data  <= 64'd0;
            timeout_err  <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_d;
            send_req     <= send_req_d;
            pid_out      <= pid_out_d;
            data_out     <= data_out_d;
            crc_type     <= crc_type_d;
            app_tx_taken <= app_tx_taken_d;
            app_rx_valid <= app_rx_valid_d;
            app_rx_data  <= app_rx_data_d;
            timeout_err  <= timeout_err_d;
            err_count    <= err_count_d;
        end
    end

    // Next-state and next-output logic; pulses default low, held values
    // default to their current contents.
    always_comb begin
        state_d        = state;
        send_req_d     = send_req;
        pid_out_d      = pid_out;
        data_out_d     = data_out;
        crc_type_d     = crc_type;
        app_tx_taken_d = 1'b0;
        app_rx_valid_d = 1'b0;
        app_rx_data_d  = app_rx_data;
        timeout_err_d  = 1'b0;
        err_count_d    = err_count;
`ifdef USB_DEV_DATA_TOGGLE_EN
        tx_toggle_d    = tx_toggle;
        rx_toggle_d    = rx_toggle;
`endif

        case (state)
            ST_IDLE: begin
                if (token_match && (pid_in == PID_IN)) begin
                    send_req_d = 1'b1;
                    if (app_tx_valid) begin
                        pid_out_d  = tx_data_pid;
                        data_out_d = app_tx_data;
                        crc_type_d = CRC_TYPE_16;
                        state_d    = ST_TX_DATA;
                    end else begin
                        pid_out_d  = PID_NAK;
                        crc_type_d = CRC_TYPE_NONE;
                        state_d    = ST_TX_HS;
                    end
                end else if (token_match && (pid_in == PID_OUT)) begin
                    state_d = ST_RX_DATA;
                end
            end

            ST_TX_DATA: begin
                if (send_done) begin
                    send_req_d = 1'b0;
                    state_d    = ST_WAIT_HS;
                end
            end

            ST_TX_HS: begin
                if (send_done) begin
                    send_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            ST_WAIT_HS: begin
                // A packet arriving on the expiry cycle takes precedence.
                if (pkt_valid) begin
                    state_d = ST_IDLE;
                    if ((pid_in == PID_ACK) && crc_correct) begin
                        app_tx_taken_d = 1'b1;
`ifdef USB_DEV_DATA_TOGGLE_EN
                        tx_toggle_d    = !tx_toggle;
`endif
                    end
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    err_count_d   = sat_inc(err_count);
                    state_d       = ST_IDLE;
                end
            end

            ST_RX_DATA: begin
                if (pkt_valid) begin
                    if (is_data_pid(pid_in)) begin
                        send_req_d = 1'b1;
                        crc_type_d = CRC_TYPE_NONE;
                        state_d    = ST_TX_HS;
                        if (!crc_correct) begin
                            pid_out_d   = PID_NAK;
                            err_count_d = sat_inc(err_count);
                        end else if (rx_dup) begin
                            pid_out_d = PID_ACK;
                        end else if (app_rx_ready) begin
                            pid_out_d      = PID_ACK;
                            app_rx_data_d  = data_in;
                            app_rx_valid_d = 1'b1;
`ifdef USB_DEV_DATA_TOGGLE_EN
                            rx_toggle_d    = !rx_toggle;
`endif
                        end else begin
                            pid_out_d = PID_NAK;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                    err_count_d   = sat_inc(err_count);
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_usb_device_protocol_fsm.sv
// Self-checking bench for usb_device_protocol_fsm: a table of per-cycle
// vectors for the basic IN/OUT flows, then hand-written sequences for the
// timeout, reset-in-transaction and (when built with
// USB_DEV_DATA_TOGGLE_EN) data-toggle behaviour.
module tb_usb_device_protocol_fsm;

    localparam int TO = 255;

    localparam logic [3:0] P_OUT = 4'h1;
    localparam logic [3:0] P_IN  = 4'h9;
    localparam logic [3:0] P_D0  = 4'h3;
    localparam logic [3:0] P_D1  = 4'hB;
    localparam logic [3:0] P_ACK = 4'h2;
    localparam logic [3:0] P_NAK = 4'hA;

    // After the table, one IN has been ACKed, so a toggling build sends DATA1.
    localparam logic [3:0] P_TO = `ifdef USB_DEV_DATA_TOGGLE_EN 4'hB `else 4'h3 `endif;

    localparam logic [63:0] DA = 64'hDEADBEEF_01234567;
    localparam logic [63:0] DB = 64'hCAFEF00D_55AA55AA;
    localparam logic [63:0] DC = 64'h11112222_33334444;
    localparam logic [63:0] DD = 64'h0F0F0F0F_A5A5A5A5;
    localparam logic [63:0] DE = 64'h12345678_9ABCDEF0;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        pkt_valid;
    logic [3:0]  pid_in;
    logic [6:0]  addr_in;
    logic [3:0]  endp_in;
    logic [63:0] data_in;
    logic        crc_correct;
    logic        send_req;
    logic        send_done;
    logic [3:0]  pid_out;
    logic [63:0] data_out;
    logic [4:0]  crc_type;
    logic        app_tx_valid;
    logic [63:0] app_tx_data;
    logic        app_tx_taken;
    logic        app_rx_ready;
    logic        app_rx_valid;
    logic [63:0] app_rx_data;
    logic        timeout_err;
    logic [7:0]  err_count;

    usb_device_protocol_fsm #(
        .DEV_ADDR(7'd5), .DEV_ENDP(4'd4), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .rst_b(rst_b), .pkt_valid(pkt_valid), .pid_in(pid_in),
        .addr_in(addr_in), .endp_in(endp_in), .data_in(data_in),
        .crc_correct(crc_correct), .send_req(send_req), .send_done(send_done),
        .pid_out(pid_out), .data_out(data_out), .crc_type(crc_type),
        .app_tx_valid(app_tx_valid), .app_tx_data(app_tx_data),
        .app_tx_taken(app_tx_taken), .app_rx_ready(app_rx_ready),
        .app_rx_valid(app_rx_valid), .app_rx_data(app_rx_data),
        .timeout_err(timeout_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic        crc;
        logic        done;
        logic        txv;
        logic        rxr;
        logic [63:0] din;
        logic        sreq;
        logic [3:0]  pido;
        logic [4:0]  crct;
        logic        taken;
        logic        rxv;
        logic        tmo;
        logic [7:0]  errc;
        logic [63:0] dout;
        logic [63:0] rxd;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [3:0] pid, input logic [6:0] a,
                         input logic [3:0] e, input logic crc, input logic done,
                         input logic txv, input logic rxr, input logic [63:0] d);
        pkt_valid    = pv;
        pid_in       = pid;
        addr_in      = a;
        endp_in      = e;
        crc_correct  = crc;
        send_done    = done;
        app_tx_valid = txv;
        app_rx_ready = rxr;
        data_in      = d;
        app_tx_data  = d;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 7'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic done_in();
        drive(1'b0, 4'h0, 7'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic pv, input logic [3:0] pid, input logic [6:0] a,
                       input logic [3:0] e, input logic crc, input logic done,
                       input logic txv, input logic rxr, input logic [63:0] d,
                       input logic sreq, input logic [3:0] pido, input logic [4:0] crct,
                       input logic tk, input logic rv, input logic to,
                       input logic [7:0] ec, input logic [63:0] dout, input logic [63:0] rxd);
        vec_t v;
        v.pv = pv; v.pid = pid; v.addr = a; v.endp = e; v.crc = crc; v.done = done;
        v.txv = txv; v.rxr = rxr; v.din = d; v.sreq = sreq; v.pido = pido; v.crct = crct;
        v.taken = tk; v.rxv = rv; v.tmo = to; v.errc = ec; v.dout = dout; v.rxd = rxd;
        tbl.push_back(v);
    endtask

    // Runaway guard.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        logic early;

        // Inputs -> expected outputs after the following rising edge.
        // IN with payload, host ACK.
        add(1, P_IN,  5, 4, 1, 0, 1, 0, DA,  1, P_D0, 16, 0, 0, 0, 0, DA, 0);
        add(0, 0,     0, 0, 0, 0, 0, 0, 0,   1, P_D0, 16, 0, 0, 0, 0, DA, 0);
        add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, P_D0, 16, 0, 0, 0, 0, DA, 0);
        add(1, P_ACK, 0, 0, 1, 0, 0, 0, 0,   0, P_D0, 16, 1, 0, 0, 0, DA, 0);
        add(0, 0,     0, 0, 0, 0, 0, 0, 0,   0, P_D0, 16, 0, 0, 0, 0, DA, 0);
        // IN with nothing queued -> NAK.
        add(1, P_IN,  5, 4, 1, 0, 0, 0, 0,   1, P_NAK, 0, 0, 0, 0, 0, DA, 0);
        add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 0, DA, 0);
        add(0, 0,     0, 0, 0, 0, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 0, DA, 0);
        // OUT + good DATA0, app ready -> ACK and payload.
        add(1, P_OUT, 5, 4, 1, 0, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 0, DA, 0);
        add(1, P_D0,  0, 0, 1, 0, 0, 1, DB,  1, P_ACK, 0, 0, 1, 0, 0, DA, DB);
        add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, P_ACK, 0, 0, 0, 0, 0, DA, DB);
        // OUT + DATA0 with bad CRC -> NAK, error counted.
        add(1, P_OUT, 5, 4, 1, 0, 0, 0, 0,   0, P_ACK, 0, 0, 0, 0, 0, DA, DB);
        add(1, P_D0,  0, 0, 0, 0, 0, 1, DC,  1, P_NAK, 0, 0, 0, 0, 1, DA, DB);
        add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 1, DA, DB);
        // OUT + good DATA1, app not ready -> NAK.
        add(1, P_OUT, 5, 4, 1, 0, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 1, DA, DB);
        add(1, P_D1,  0, 0, 1, 0, 0, 0, DC,  1, P_NAK, 0, 0, 0, 0, 1, DA, DB);
        add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 1, DA, DB);
        // OUT + good DATA1, app ready -> accepted.
        add(1, P_OUT, 5, 4, 1, 0, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 1, DA, DB);
        add(1, P_D1,  0, 0, 1, 0, 0, 1, DC,  1, P_ACK, 0, 0, 1, 0, 1, DA, DC);
        add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        // OUT followed by a non-DATA packet -> back to idle silently.
        add(1, P_OUT, 5, 4, 1, 0, 0, 0, 0,   0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        add(1, P_ACK, 0, 0, 1, 0, 0, 0, 0,   0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        add(0, 0,     0, 0, 0, 0, 0, 0, 0,   0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        // Wrong address, bad CRC, wrong endpoint -> ignored.
        add(1, P_IN,  6, 4, 1, 0, 1, 0, DB,  0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        add(1, P_IN,  5, 4, 0, 0, 1, 0, DB,  0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        add(1, P_IN,  5, 3, 1, 0, 1, 0, DB,  0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        add(0, 0,     0, 0, 0, 0, 0, 0, 0,   0, P_ACK, 0, 0, 0, 0, 1, DA, DC);
        // Packet during handshake transmit is ignored; send_req held.
        add(1, P_IN,  5, 4, 1, 0, 0, 0, 0,   1, P_NAK, 0, 0, 0, 0, 1, DA, DC);
        add(1, P_ACK, 0, 0, 1, 0, 0, 0, 0,   1, P_NAK, 0, 0, 0, 0, 1, DA, DC);
        add(0, 0,     0, 0, 0, 1, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 1, DA, DC);
        add(0, 0,     0, 0, 0, 0, 0, 0, 0,   0, P_NAK, 0, 0, 0, 0, 1, DA, DC);

        // Reset state.
        rst_b = 1'b0;
        idle();
        tick();
        tick();
        chk("reset send_req", 64'(send_req), 64'd0);
        chk("reset pid_out", 64'(pid_out), 64'd0);
        chk("reset data_out", data_out, 64'd0);
        chk("reset crc_type", 64'(crc_type), 64'd0);
        chk("reset err_count", 64'(err_count), 64'd0);
        chk("reset app_rx_data", app_rx_data, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        // Table.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pv, tbl[i].pid, tbl[i].addr, tbl[i].endp, tbl[i].crc,
                  tbl[i].done, tbl[i].txv, tbl[i].rxr, tbl[i].din);
            tick();
            chk($sformatf("row%0d send_req", i), 64'(send_req), 64'(tbl[i].sreq));
            chk($sformatf("row%0d pid_out", i), 64'(pid_out), 64'(tbl[i].pido));
            chk($sformatf("row%0d crc_type", i), 64'(crc_type), 64'(tbl[i].crct));
            chk($sformatf("row%0d app_tx_taken", i), 64'(app_tx_taken), 64'(tbl[i].taken));
            chk($sformatf("row%0d app_rx_valid", i), 64'(app_rx_valid), 64'(tbl[i].rxv));
            chk($sformatf("row%0d timeout_err", i), 64'(timeout_err), 64'(tbl[i].tmo));
            chk($sformatf("row%0d err_count", i), 64'(err_count), 64'(tbl[i].errc));
            chk($sformatf("row%0d data_out", i), data_out, tbl[i].dout);
            chk($sformatf("row%0d app_rx_data", i), app_rx_data, tbl[i].rxd);
        end

        // IN, DATA sent, host silent. The timer reads TO on the TO-th cycle
        // after the WAIT_HS entry edge; the registered pulse follows one edge later.
        drive(1'b1, P_IN, 7'd5, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, DD);
        tick();
        chk("to1 send_req", 64'(send_req), 64'd1);
        chk("to1 pid_out", 64'(pid_out), 64'(P_TO));
        chk("to1 data_out", data_out, DD);
        done_in();
        tick();
        idle();
        first = 0;
        for (int n = 1; n <= TO + 8; n++) begin
            tick();
            if (timeout_err === 1'b1) begin
                first = n;
                break;
            end
        end
        chk("to1 timeout latency", 64'(first), 64'(TO + 1));
        chk("to1 err_count", 64'(err_count), 64'd2);
        chk("to1 app_tx_taken", 64'(app_tx_taken), 64'd0);
        tick();
        chk("to1 pulse width", 64'(timeout_err), 64'd0);

        // ACK lands on the expiry cycle: packet wins, no timeout.
        drive(1'b1, P_IN, 7'd5, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, DD);
        tick();
        chk("to2 pid_out", 64'(pid_out), 64'(P_TO));
        done_in();
        tick();
        idle();
        early = 1'b0;
        repeat (TO) begin
            tick();
            if (timeout_err !== 1'b0) early = 1'b1;
        end
        chk("to2 no early timeout", 64'(early), 64'd0);
        drive(1'b1, P_ACK, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk("to2 app_tx_taken", 64'(app_tx_taken), 64'd1);
        chk("to2 timeout_err", 64'(timeout_err), 64'd0);
        chk("to2 err_count", 64'(err_count), 64'd2);
        idle();
        tick();
        chk("to2 taken pulse width", 64'(app_tx_taken), 64'd0);
        chk("to2 no late timeout", 64'(timeout_err), 64'd0);

        // Reset asserted while waiting for the handshake.
        drive(1'b1, P_IN, 7'd5, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, DE);
        tick();
        done_in();
        tick();
        idle();
        tick();
        tick();
        #2 rst_b = 1'b0;
        #1;
        chk("rst send_req", 64'(send_req), 64'd0);
        chk("rst pid_out", 64'(pid_out), 64'd0);
        chk("rst data_out", data_out, 64'd0);
        chk("rst crc_type", 64'(crc_type), 64'd0);
        chk("rst err_count", 64'(err_count), 64'd0);
        chk("rst app_rx_data", app_rx_data, 64'd0);
        chk("rst pulses", 64'({app_tx_taken, app_rx_valid, timeout_err}), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        drive(1'b1, P_ACK, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk("rst late ack ignored", 64'(app_tx_taken), 64'd0);
        drive(1'b1, P_IN, 7'd5, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk("rst idle send_req", 64'(send_req), 64'd1);
        chk("rst idle pid_out", 64'(pid_out), 64'(P_NAK));
        done_in();
        tick();
        idle();
        tick();

`ifdef USB_DEV_DATA_TOGGLE_EN
        // Two ACKed IN transactions alternate DATA0 / DATA1.
        drive(1'b1, P_IN, 7'd5, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, DA);
        tick();
        chk("tog in1 pid_out", 64'(pid_out), 64'(P_D0));
        done_in();
        tick();
        drive(1'b1, P_ACK, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk("tog in1 taken", 64'(app_tx_taken), 64'd1);
        drive(1'b1, P_IN, 7'd5, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, DB);
        tick();
        chk("tog in2 pid_out", 64'(pid_out), 64'(P_D1));
        chk("tog in2 data_out", data_out, DB);
        done_in();
        tick();
        drive(1'b1, P_ACK, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        // Repeated OUT DATA0: second one is a duplicate.
        drive(1'b1, P_OUT, 7'd5, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(1'b1, P_D0, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, DC);
        tick();
        chk("tog out1 rx_valid", 64'(app_rx_valid), 64'd1);
        chk("tog out1 rx_data", app_rx_data, DC);
        chk("tog out1 pid_out", 64'(pid_out), 64'(P_ACK));
        done_in();
        tick();
        drive(1'b1, P_OUT, 7'd5, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        drive(1'b1, P_D0, 7'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, DD);
        tick();
        chk("tog out2 rx_valid", 64'(app_rx_valid), 64'd0);
        chk("tog out2 send_req", 64'(send_req), 64'd1);
        chk("tog out2 pid_out", 64'(pid_out), 64'(P_ACK));
        chk("tog out2 rx_data held", app_rx_data, DC);
        done_in();
        tick();
        idle();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
